// File: rtl/vga_fml_scheduler.sv
// Shares the VGA frame-buffer FML port between CPU and LCD fetcher.
// Define VGA_FML_WDOG_EN to add the bus watchdog and fml_timeout_o.
module vga_fml_scheduler #(
  parameter int fml_depth      = 20,
  parameter int CPU_STARVE_MAX = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [18:0]          cpu_adr_i,
  input  logic [1:0]           cpu_sel_i,
  input  logic                 cpu_we_i,
  input  logic [15:0]          cpu_dat_i,
  output logic [15:0]          cpu_dat_o,
  input  logic                 cpu_stb_i,
  output logic                 cpu_ack_o,
  input  logic [18:0]          lcd_adr_i,
  input  logic [1:0]           lcd_sel_i,
  input  logic                 lcd_cyc_i,
  input  logic                 lcd_stb_i,
  output logic [15:0]          lcd_dat_o,
  output logic                 lcd_ack_o,
  output logic [fml_depth-1:0] fml_adr_o,
  output logic                 fml_stb_o,
  output logic                 fml_we_o,
  output logic [1:0]           fml_sel_o,
  output logic [15:0]          fml_do,
  input  logic [15:0]          fml_di,
  input  logic                 fml_ack_i
`ifdef VGA_FML_WDOG_EN
  ,
  output logic                 fml_timeout_o
`endif
);

  typedef enum logic [1:0] {IDLE, CPU_BUS, LCD_BUS, ACK} state_t;

  state_t               state_q, state_d;
  logic                 lcd_gnt_q, lcd_gnt_d;
  logic [3:0]           starve_q, starve_d;
  logic [fml_depth-1:0] fml_adr_q, fml_adr_d;
  logic [1:0]           fml_sel_q, fml_sel_d;
  logic                 fml_we_q, fml_we_d;
  logic                 fml_stb_q, fml_stb_d;
  logic [15:0]          fml_do_q, fml_do_d;
  logic [15:0]          cpu_dat_q, cpu_dat_d;
  logic [15:0]          lcd_dat_q, lcd_dat_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic                 lcd_ack_q, lcd_ack_d;
`ifdef VGA_FML_WDOG_EN
  logic [7:0]           wdog_q, wdog_d;
  logic                 tmo_q, tmo_d;
`endif

  logic        lcd_req, cpu_req, cpu_forced;
  logic        rsp, capture;
  logic [15:0] rdata;

  assign lcd_req    = lcd_cyc_i & lcd_stb_i;
  assign cpu_req    = cpu_stb_i;
  assign cpu_forced = cpu_req && (starve_q == 4'(CPU_STARVE_MAX));

  always_comb begin
    state_d   = state_q;
    lcd_gnt_d = lcd_gnt_q;
    starve_d  = starve_q;
    fml_adr_d = fml_adr_q;
    fml_sel_d = fml_sel_q;
    fml_we_d  = fml_we_q;
    fml_stb_d = fml_stb_q;
    fml_do_d  = fml_do_q;
    cpu_dat_d = cpu_dat_q;
    lcd_dat_d = lcd_dat_q;
    cpu_ack_d = 1'b0;
    lcd_ack_d = 1'b0;
    rsp       = 1'b0;
    capture   = 1'b0;
    rdata     = fml_di;
`ifdef VGA_FML_WDOG_EN
    wdog_d    = wdog_q;
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (lcd_req && !cpu_forced) begin
          state_d   = LCD_BUS;
          lcd_gnt_d = 1'b1;
          fml_adr_d = fml_depth'({lcd_adr_i, 1'b0});
          fml_sel_d = lcd_sel_i;
          fml_we_d  = 1'b0;
          fml_stb_d = 1'b1;
          if (!cpu_req)
            starve_d = 4'd0;
          else if (starve_q != 4'(CPU_STARVE_MAX))
            starve_d = starve_q + 4'd1;
`ifdef VGA_FML_WDOG_EN
          wdog_d    = 8'd0;
`endif
        end else if (cpu_req) begin
          state_d   = CPU_BUS;
          lcd_gnt_d = 1'b0;
          fml_adr_d = fml_depth'({cpu_adr_i, 1'b0});
          fml_sel_d = cpu_sel_i;
          fml_we_d  = cpu_we_i;
          fml_do_d  = cpu_dat_i;
          fml_stb_d = 1'b1;
          starve_d  = 4'd0;
`ifdef VGA_FML_WDOG_EN
          wdog_d    = 8'd0;
`endif
        end
      end
      CPU_BUS, LCD_BUS: begin
        rsp     = fml_ack_i;
        capture = lcd_gnt_q | ~fml_we_q;
`ifdef VGA_FML_WDOG_EN
        wdog_d  = wdog_q + 8'd1;
        // A dead slave still gets the requester its ack, with poisoned data.
        if (!fml_ack_i && wdog_q == 8'hFF) begin
          rsp     = 1'b1;
          capture = 1'b1;
          rdata   = 16'hFFFF;
          tmo_d   = 1'b1;
        end
`endif
        if (rsp) begin
          state_d   = ACK;
          fml_stb_d = 1'b0;
          if (lcd_gnt_q) begin
            lcd_ack_d = 1'b1;
            lcd_dat_d = rdata;
          end else begin
            cpu_ack_d = 1'b1;
            if (capture)
              cpu_dat_d = rdata;
          end
        end
      end
      ACK: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      lcd_gnt_q <= 1'b0;
      starve_q  <= 4'd0;
      fml_adr_q <= '0;
      fml_sel_q <= 2'b00;
      fml_we_q  <= 1'b0;
      fml_stb_q <= 1'b0;
      fml_do_q  <= 16'h0000;
      cpu_dat_q <= 16'h0000;
      lcd_dat_q <= 16'h0000;
      cpu_ack_q <= 1'b0;
      lcd_ack_q <= 1'b0;
`ifdef VGA_FML_WDOG_EN
      wdog_q    <= 8'd0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lcd_gnt_q <= lcd_gnt_d;
      starve_q  <= starve_d;
      fml_adr_q <= fml_adr_d;
      fml_sel_q <= fml_sel_d;
      fml_we_q  <= fml_we_d;
      fml_stb_q <= fml_stb_d;
      fml_do_q  <= fml_do_d;
      cpu_dat_q <= cpu_dat_d;
      lcd_dat_q <= lcd_dat_d;
      cpu_ack_q <= cpu_ack_d;
      lcd_ack_q <= lcd_ack_d;
`ifdef VGA_FML_WDOG_EN
      wdog_q    <= wdog_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign fml_adr_o = fml_adr_q;
  assign fml_sel_o = fml_sel_q;
  assign fml_we_o  = fml_we_q;
  assign fml_stb_o = fml_stb_q;
  assign fml_do    = fml_do_q;
  assign cpu_dat_o = cpu_dat_q;
  assign lcd_dat_o = lcd_dat_q;
  assign cpu_ack_o = cpu_ack_q;
  assign lcd_ack_o = lcd_ack_q;
`ifdef VGA_FML_WDOG_EN
  assign fml_timeout_o = tmo_q;
`endif

endmodule

// File: tb/tb_vga_fml_scheduler.sv
// Scoreboard bench for vga_fml_scheduler: directed CPU/LCD traffic
// against a scripted FML slave, checked by an independent monitor.
module tb_vga_fml_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] cpu_adr_i = '0;
  logic [1:0]  cpu_sel_i = '0;
  logic        cpu_we_i  = 1'b0;
  logic [15:0] cpu_dat_i = '0;
  logic [15:0] cpu_dat_o;
  logic        cpu_stb_i = 1'b0;
  logic        cpu_ack_o;
  logic [18:0] lcd_adr_i = '0;
  logic [1:0]  lcd_sel_i = '0;
  logic        lcd_cyc_i = 1'b0;
  logic        lcd_stb_i = 1'b0;
  logic [15:0] lcd_dat_o;
  logic        lcd_ack_o;
  logic [19:0] fml_adr_o;
  logic        fml_stb_o;
  logic        fml_we_o;
  logic [1:0]  fml_sel_o;
  logic [15:0] fml_do;
  logic [15:0] fml_di = '0;
  logic        fml_ack_i = 1'b0;

  vga_fml_scheduler #(.fml_depth(20), .CPU_STARVE_MAX(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cpu_adr_i(cpu_adr_i), .cpu_sel_i(cpu_sel_i), .cpu_we_i(cpu_we_i),
    .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o), .cpu_stb_i(cpu_stb_i),
    .cpu_ack_o(cpu_ack_o),
    .lcd_adr_i(lcd_adr_i), .lcd_sel_i(lcd_sel_i), .lcd_cyc_i(lcd_cyc_i),
    .lcd_stb_i(lcd_stb_i), .lcd_dat_o(lcd_dat_o), .lcd_ack_o(lcd_ack_o),
    .fml_adr_o(fml_adr_o), .fml_stb_o(fml_stb_o), .fml_we_o(fml_we_o),
    .fml_sel_o(fml_sel_o), .fml_do(fml_do), .fml_di(fml_di),
    .fml_ack_i(fml_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] adr;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] dat;
    int          len;
    int          period;
  } fml_t;

  fml_t        exp_fml[$];
  logic [15:0] exp_cpu[$];
  logic [15:0] exp_lcd[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_delay = 0;
  int ack_cyc = 0;
  logic [15:0] rd_data = '0;
  logic stray = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_fml(input logic [19:0] a, input logic w,
                                   input logic [1:0] s, input logic [15:0] d,
                                   input int len, input int per);
    fml_t e;
    e.adr = a; e.we = w; e.sel = s; e.dat = d; e.len = len; e.period = per;
    exp_fml.push_back(e);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scripted FML slave: acks after ack_delay strobe cycles, data keyed by address
  int wcnt = 0;
  always @(negedge clk) begin
    fml_ack_i = stray;
    if (fml_stb_o && !rst) begin
      if (wcnt >= ack_delay) begin
        fml_ack_i = 1'b1;
        fml_di    = rd_data ^ fml_adr_o[16:1];
        ack_cyc   = cyc;
      end
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // Monitor
  logic stb_prev = 1'b0, cack_prev = 1'b0, lack_prev = 1'b0;
  int   len = 0, len_exp = 0, last_rise = 0;
  always @(negedge clk) begin
    if (rst) begin
      stb_prev  = 1'b0;
      cack_prev = 1'b0;
      lack_prev = 1'b0;
      len_exp   = 0;
    end else begin
      if (fml_stb_o && !stb_prev) begin
        if (exp_fml.size() == 0) begin
          chk("unexpected_fml_stb", 1, 0);
        end else begin
          fml_t e;
          e = exp_fml.pop_front();
          chk("fml_adr", 32'(fml_adr_o), 32'(e.adr));
          chk("fml_we", 32'(fml_we_o), 32'(e.we));
          chk("fml_sel", 32'(fml_sel_o), 32'(e.sel));
          chk("fml_do", 32'(fml_do), 32'(e.dat));
          if (e.period != 0) chk("stb_period", cyc - last_rise, e.period);
          len_exp = e.len;
        end
        last_rise = cyc;
        len = 0;
      end
      if (fml_stb_o) len++;
      if (!fml_stb_o && stb_prev && len_exp != 0) chk("stb_len", len, len_exp);
      stb_prev = fml_stb_o;
      if (cpu_ack_o) begin
        chk("cpu_ack_pulse", 32'(cack_prev), 0);
        chk("cpu_ack_lat", cyc - ack_cyc, 1);
        if (exp_cpu.size() == 0) chk("unexpected_cpu_ack", 1, 0);
        else chk("cpu_dat_o", 32'(cpu_dat_o), 32'(exp_cpu.pop_front()));
      end
      if (lcd_ack_o) begin
        chk("lcd_ack_pulse", 32'(lack_prev), 0);
        chk("lcd_ack_lat", cyc - ack_cyc, 1);
        if (exp_lcd.size() == 0) chk("unexpected_lcd_ack", 1, 0);
        else chk("lcd_dat_o", 32'(lcd_dat_o), 32'(exp_lcd.pop_front()));
      end
      cack_prev = cpu_ack_o;
      lack_prev = lcd_ack_o;
    end
  end

  task automatic do_cpu(input logic [18:0] a, input logic [1:0] s,
                        input logic w, input logic [15:0] d);
    bit got = 0;
    cpu_adr_i = a; cpu_sel_i = s; cpu_we_i = w; cpu_dat_i = d;
    cpu_stb_i = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack_o) got = 1;
    end
    if (!got) chk("cpu_ack_timeout", 0, 1);
    cpu_stb_i = 1'b0;
  endtask

  task automatic do_lcd(input logic [18:0] a, input logic [1:0] s,
                        input int n);
    int acks = 0;
    lcd_adr_i = a; lcd_sel_i = s;
    lcd_cyc_i = 1'b1; lcd_stb_i = 1'b1;
    for (int i = 0; i < 600 && acks < n; i++) begin
      @(negedge clk);
      if (lcd_ack_o) acks++;
    end
    if (acks < n) chk("lcd_ack_timeout", acks, n);
    lcd_cyc_i = 1'b0; lcd_stb_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fml_stb", 32'(fml_stb_o), 0);
    chk("rst_fml_we", 32'(fml_we_o), 0);
    chk("rst_fml_adr", 32'(fml_adr_o), 0);
    chk("rst_fml_sel", 32'(fml_sel_o), 0);
    chk("rst_fml_do", 32'(fml_do), 0);
    chk("rst_cpu_dat", 32'(cpu_dat_o), 0);
    chk("rst_lcd_dat", 32'(lcd_dat_o), 0);
    chk("rst_cpu_ack", 32'(cpu_ack_o), 0);
    chk("rst_lcd_ack", 32'(lcd_ack_o), 0);

    // CPU write, ack two cycles into the strobe
    ack_delay = 2;
    push_fml(20'h00246, 1'b1, 2'b11, 16'hA5C3, 3, 0);
    exp_cpu.push_back(16'h0000);
    do_cpu(19'h00123, 2'b11, 1'b1, 16'hA5C3);
    repeat (3) @(negedge clk);

    // LCD read, strobe dropped on the ack edge
    ack_delay = 0;
    rd_data = 16'h1234;
    push_fml(20'h20000, 1'b0, 2'b11, 16'hA5C3, 1, 0);
    exp_lcd.push_back(16'h1234);
    do_lcd(19'h10000, 2'b11, 1);
    repeat (5) @(negedge clk);

    // Stray slave ack while idle must be ignored
    stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_stb", 32'(fml_stb_o), 0);

    // Arbitration: four LCD grants, forced CPU read, then LCD again
    rd_data = 16'h1111;
    for (int i = 0; i < 4; i++)
      push_fml(20'h00080, 1'b0, 2'b01, 16'hA5C3, 1, (i == 0) ? 0 : 3);
    push_fml(20'h000EE, 1'b0, 2'b11, 16'h7777, 1, 3);
    push_fml(20'h00080, 1'b0, 2'b01, 16'h7777, 1, 3);
    for (int i = 0; i < 5; i++) exp_lcd.push_back(16'h1151);
    exp_cpu.push_back(16'h1166);
    fork
      do_cpu(19'h00077, 2'b11, 1'b0, 16'h7777);
      do_lcd(19'h00040, 2'b01, 5);
    join
    repeat (5) @(negedge clk);

    // Reset while the LCD holds the bus
    ack_delay = 100;
    push_fml(20'h00200, 1'b0, 2'b01, 16'h7777, 0, 0);
    lcd_adr_i = 19'h00100; lcd_sel_i = 2'b01;
    lcd_cyc_i = 1'b1; lcd_stb_i = 1'b1;
    for (int i = 0; i < 20 && !fml_stb_o; i++) @(negedge clk);
    chk("lcd_bus_stb", 32'(fml_stb_o), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_stb", 32'(fml_stb_o), 0);
    chk("async_rst_lack", 32'(lcd_ack_o), 0);
    chk("async_rst_ldat", 32'(lcd_dat_o), 0);
    lcd_cyc_i = 1'b0; lcd_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Served normally after reset; fml_do back to its reset value
    ack_delay = 0;
    rd_data = 16'hABCD;
    push_fml(20'h0000A, 1'b0, 2'b10, 16'h0000, 1, 0);
    exp_lcd.push_back(16'hABC8);
    do_lcd(19'h00005, 2'b10, 1);
    repeat (3) @(negedge clk);

    // Top-of-range CPU write with a one-cycle wait
    ack_delay = 1;
    push_fml(20'hFFFFE, 1'b1, 2'b10, 16'h5A5A, 2, 0);
    exp_cpu.push_back(16'h0000);
    do_cpu(19'h7FFFF, 2'b10, 1'b1, 16'h5A5A);
    repeat (5) @(negedge clk);

    chk("fml_queue_empty", exp_fml.size(), 0);
    chk("cpu_queue_empty", exp_cpu.size(), 0);
    chk("lcd_queue_empty", exp_lcd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
